// File: rtl/sd_pkg.sv
// Shared constants and types for the sigma-delta modulator and its matching decimator.
// Derived widths follow from the sample width and the oversampling ratio.
package sd_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_OSR_LOG2 = 6;
    localparam int DEF_OSR      = 1 << DEF_OSR_LOG2;
    localparam int DEF_LEVEL_W  = DEF_DATA_W + DEF_OSR_LOG2;
    localparam int DEF_ACC_W    = DEF_LEVEL_W + 1;
    localparam logic [DEF_ACC_W-1:0] DEF_FS = DEF_ACC_W'(1) << DEF_LEVEL_W;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sd_state_e;

endpackage

// File: rtl/sd_mod_core.sv
// First-order sigma-delta core: error accumulator plus comparator against full scale.
// BIT is registered; acc and BIT freeze while EN is low.
module sd_mod_core
    import sd_pkg::*;
#(
    parameter int LEVEL_W = DEF_LEVEL_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic [LEVEL_W-1:0] LEVEL,
    output logic               BIT
);

    localparam int ACC_W = LEVEL_W + 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum;
    logic             bit_q, bit_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sum   = acc_q + {1'b0, LEVEL};
        acc_d = acc_q;
        bit_d = bit_q;
        if (EN) begin
            // acc < FS and LEVEL < FS, so sum < 2*FS and its top bit is exactly (sum >= FS).
            bit_d = sum[LEVEL_W];
            acc_d = {1'b0, sum[LEVEL_W-1:0]};
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            acc_q <= '0;
            bit_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            bit_q <= bit_d;
        end
    end

    assign BIT = bit_q;

endmodule

// File: rtl/sigma_delta_modulator.sv
// PCM-to-bitstream modulator: accepts one sample every OSR clocks, linearly interpolates
// between consecutive samples and feeds the interpolated level to the sigma-delta core.
module sigma_delta_modulator
    import sd_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int OSR_LOG2 = DEF_OSR_LOG2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic              OUT,
    output logic              UNDERRUN
);

    localparam int K       = OSR_LOG2;
    localparam int LEVEL_W = DATA_W + K;
    localparam int DELTA_W = DATA_W + 1;
    localparam logic [K-1:0] LAST_PHASE = '1;

    sd_state_e                  state_q, state_d;
    logic [K-1:0]               n_q, n_d;
    logic [DATA_W-1:0]          cur_q, cur_d;
    logic signed [DELTA_W-1:0]  delta_q, delta_d;
    logic [LEVEL_W-1:0]         lvl_q, lvl_d;
    logic                       und_q, und_d;
    logic                       take;

    assign IN_READY = RST && ((state_q == IDLE) || (n_q == LAST_PHASE));
    assign take     = IN_VALID && IN_READY;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cur_d   = cur_q;
        delta_d = delta_q;
        lvl_d   = lvl_q;
        und_d   = 1'b0;
        if (state_q == RUN) begin
            lvl_d = lvl_q + {{(LEVEL_W - DELTA_W){delta_q[DELTA_W-1]}}, delta_q};
            n_d   = n_q + 1'b1;
        end
        if (take) begin
            // Ramp restarts at the old level and reaches IN_DATA<<K after exactly OSR steps.
            delta_d = $signed({1'b0, IN_DATA}) - $signed({1'b0, cur_q});
            lvl_d   = {cur_q, {K{1'b0}}};
            n_d     = '0;
            cur_d   = IN_DATA;
            state_d = RUN;
        end else if (state_q == RUN && n_q == LAST_PHASE) begin
            delta_d = '0;
            lvl_d   = {cur_q, {K{1'b0}}};
            und_d   = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            n_q     <= '0;
            cur_q   <= '0;
            delta_q <= '0;
            lvl_q   <= '0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cur_q   <= cur_d;
            delta_q <= delta_d;
            lvl_q   <= lvl_d;
            und_q   <= und_d;
        end
    end

    sd_mod_core #(
        .LEVEL_W (LEVEL_W)
    ) u_core (
        .CLK   (CLK),
        .RST   (RST),
        .EN    (state_q == RUN),
        .LEVEL (lvl_q),
        .BIT   (OUT)
    );

    assign UNDERRUN = und_q;

endmodule
